// File: rtl/vga_text_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_text_gen
// Brief    : Parametrised raster text/semigraphics-4 generator with test
//            pattern, per-frame base latch and frame_start strobe.
// Revision : 1.0 - initial release
// ============================================================================
module vga_text_gen #(
  parameter int H_RES        = 800,
  parameter int H_SYNC_START = 840,
  parameter int H_SYNC_STOP  = 968,
  parameter int H_TOTAL      = 1056,
  parameter int V_RES        = 600,
  parameter int V_SYNC_START = 601,
  parameter int V_SYNC_STOP  = 605,
  parameter int V_TOTAL      = 628,
  parameter int HS_POL       = 1,
  parameter int VS_POL       = 1,
  parameter int WIN_X        = 144,
  parameter int WIN_Y        = 12,
  parameter int COLS         = 32,
  parameter int ROWS         = 16,
  parameter int CHAR_H       = 12,
  parameter int H_SCALE      = 2,
  parameter int V_SCALE      = 3,
  parameter int FONT_AW      = 12
) (
  input  logic               pixel_clock,
  input  logic               reset_n,
  input  logic [15:0]        display_base,
  input  logic               test_pattern,
  input  logic               css,
  output logic [15:0]        ram_addr,
  input  logic [7:0]         ram_data,
  output logic [FONT_AW-1:0] font_addr,
  input  logic [7:0]         font_data,
  output logic               hsync,
  output logic               vsync,
  output logic               blank,
  output logic [7:0]         red,
  output logic [7:0]         green,
  output logic [7:0]         blue,
  output logic               frame_start
);

  // Counters are at least 9 bits so the test pattern can always use h/v[8:0].
  localparam int HW   = ($clog2(H_TOTAL) < 9) ? 9 : $clog2(H_TOTAL);
  localparam int VW   = ($clog2(V_TOTAL) < 9) ? 9 : $clog2(V_TOTAL);
  localparam int CELL = 8 * H_SCALE;
  localparam int PW   = $clog2(CELL);
  localparam int CW   = $clog2(COLS + 1);
  localparam int GW   = $clog2(CHAR_H + 1);
  localparam int VSW  = $clog2(V_SCALE + 1);
  localparam int HSW  = $clog2(H_SCALE + 1);

  localparam logic [HW-1:0]  C_H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]  C_H_RES     = HW'(H_RES);
  localparam logic [HW-1:0]  C_HS_START  = HW'(H_SYNC_START);
  localparam logic [HW-1:0]  C_HS_STOP   = HW'(H_SYNC_STOP);
  localparam logic [HW-1:0]  C_REG_START = HW'(WIN_X - CELL);
  localparam logic [HW-1:0]  C_REG_STOP  = HW'(WIN_X + COLS * CELL);
  localparam logic [VW-1:0]  C_V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]  C_V_RES     = VW'(V_RES);
  localparam logic [VW-1:0]  C_VS_START  = VW'(V_SYNC_START);
  localparam logic [VW-1:0]  C_VS_STOP   = VW'(V_SYNC_STOP);
  localparam logic [VW-1:0]  C_WIN_Y     = VW'(WIN_Y);
  localparam logic [VW-1:0]  C_WIN_Y_END = VW'(WIN_Y + ROWS * CHAR_H * V_SCALE);
  localparam logic [PW-1:0]  C_PH_LAST   = PW'(CELL - 1);
  localparam logic [PW-1:0]  C_PH_ADDR   = PW'(0);
  localparam logic [PW-1:0]  C_PH_CODE   = PW'(2);
  localparam logic [PW-1:0]  C_PH_FONT   = PW'(3);
  localparam logic [PW-1:0]  C_PH_GLYPH  = PW'(5);
  localparam logic [CW-1:0]  C_COLS      = CW'(COLS);
  localparam logic [GW-1:0]  C_G_LAST    = GW'(CHAR_H - 1);
  localparam logic [GW-1:0]  C_G_HALF    = GW'(CHAR_H / 2);
  localparam logic [VSW-1:0] C_VSC_LAST  = VSW'(V_SCALE - 1);
  localparam logic [HSW-1:0] C_HSC_LAST  = HSW'(H_SCALE - 1);
  localparam logic           C_HS_ACT    = (HS_POL != 0);
  localparam logic           C_VS_ACT    = (VS_POL != 0);

  logic [HW-1:0]      r_h;
  logic [VW-1:0]      r_v;
  logic [PW-1:0]      r_phase;
  logic [CW-1:0]      r_col;
  logic [VSW-1:0]     r_vsub;
  logic [GW-1:0]      r_grow;
  logic [15:0]        r_line_start;
  logic [7:0]         r_code, r_next_code, r_next_bitmap, r_shift, r_dcode;
  logic [HSW-1:0]     r_hsub;
  logic [2:0]         r_gpx;
  logic [15:0]        r_ram_addr;
  logic [FONT_AW-1:0] r_font_addr;
  logic               r_hsync, r_vsync, r_blank, r_frame_start;
  logic [23:0]        r_rgb;

  logic               w_active, w_win_line, w_region, w_cell_start, w_win;
  logic               w_frame, w_line_end, w_top, w_quad_on;
  logic [7:0]         w_bits, w_code;
  logic [HSW-1:0]     w_hsub;
  logic [2:0]         w_gpx;
  logic [FONT_AW-1:0] w_font_addr;
  logic [23:0]        w_rgb;

  function automatic logic [23:0] sg_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'h07FF00;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h3B08FF;
      3'd3:    return 24'hCC003B;
      3'd4:    return 24'hFFFFFF;
      3'd5:    return 24'h07E399;
      3'd6:    return 24'hFF1CFF;
      default: return 24'hFF8100;
    endcase
  endfunction

  assign w_active     = (r_h < C_H_RES) && (r_v < C_V_RES);
  assign w_win_line   = (r_v >= C_WIN_Y) && (r_v < C_WIN_Y_END);
  assign w_region     = (r_h >= C_REG_START) && (r_h < C_REG_STOP);
  assign w_cell_start = w_region && (r_phase == '0) && (r_col != '0);
  assign w_win        = w_win_line && w_region && (r_col != '0);
  assign w_frame      = (r_h == '0) && (r_v == C_VS_START);
  assign w_line_end   = (r_h == C_H_LAST);
  // The first clock of a cell shows the freshly fetched glyph directly.
  assign w_bits       = w_cell_start ? r_next_bitmap : r_shift;
  assign w_code       = w_cell_start ? r_next_code   : r_dcode;
  assign w_hsub       = w_cell_start ? '0 : r_hsub;
  assign w_gpx        = w_cell_start ? '0 : r_gpx;
  assign w_top        = (r_grow < C_G_HALF);
  assign w_font_addr  = FONT_AW'({~r_code[6], r_code[5:0]} * CHAR_H) + FONT_AW'(r_grow);

  always_comb begin
    w_quad_on = 1'b0;
    case ({w_top, w_gpx[2]})
      2'b10:   w_quad_on = w_code[3];
      2'b11:   w_quad_on = w_code[2];
      2'b00:   w_quad_on = w_code[1];
      default: w_quad_on = w_code[0];
    endcase
    w_rgb = 24'h000000;
    if (w_active) begin
      if (test_pattern)
        w_rgb = {r_h[7:0] ^ r_v[7:0], r_h[8:1], r_v[8:1]};
      else if (w_win && w_code[7])
        w_rgb = w_quad_on ? sg_colour(w_code[6:4]) : 24'h000000;
      else if (w_win && !w_bits[7])
        w_rgb = css ? 24'hFF8100 : 24'h07FF00;
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (!reset_n) begin
      r_h <= '0; r_v <= '0; r_phase <= '0; r_col <= '0;
      r_vsub <= '0; r_grow <= '0;
      r_line_start <= display_base;
      r_code <= '0; r_next_code <= '0; r_next_bitmap <= '0;
      r_shift <= '0; r_dcode <= '0; r_hsub <= '0; r_gpx <= '0;
      r_ram_addr <= display_base;
      r_font_addr <= '0;
      r_hsync <= ~C_HS_ACT;
      r_vsync <= ~C_VS_ACT;
      r_blank <= 1'b0;
      r_frame_start <= 1'b0;
      r_rgb <= '0;
    end else begin
      if (w_line_end) begin
        r_h <= '0;
        r_v <= (r_v == C_V_LAST) ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end

      if (w_region) begin
        if (r_phase == C_PH_LAST) begin
          r_phase <= '0;
          r_col   <= r_col + 1'b1;
        end else begin
          r_phase <= r_phase + 1'b1;
        end
      end else begin
        r_phase <= '0;
        r_col   <= '0;
      end

      if (w_win_line && w_region && (r_col != C_COLS)) begin
        if (r_phase == C_PH_ADDR)  r_ram_addr  <= r_line_start + 16'(r_col);
        if (r_phase == C_PH_CODE)  r_code      <= ram_data;
        if (r_phase == C_PH_FONT)  r_font_addr <= w_font_addr;
        if (r_phase == C_PH_GLYPH) begin
          r_next_bitmap <= font_data;
          r_next_code   <= r_code;
        end
      end

      if (w_frame) begin
        r_line_start <= display_base;
        r_vsub <= '0;
        r_grow <= '0;
      end else if (w_line_end && w_win_line) begin
        if (r_vsub == C_VSC_LAST) begin
          r_vsub <= '0;
          if (r_grow == C_G_LAST) begin
            r_grow <= '0;
            r_line_start <= r_line_start + 16'(COLS);
          end else begin
            r_grow <= r_grow + 1'b1;
          end
        end else begin
          r_vsub <= r_vsub + 1'b1;
        end
      end

      r_dcode <= w_code;
      if (w_hsub == C_HSC_LAST) begin
        r_hsub  <= '0;
        r_shift <= {w_bits[6:0], 1'b0};
        r_gpx   <= w_gpx + 1'b1;
      end else begin
        r_hsub  <= w_hsub + 1'b1;
        r_shift <= w_bits;
        r_gpx   <= w_gpx;
      end

      r_hsync <= ((r_h >= C_HS_START) && (r_h < C_HS_STOP)) ? C_HS_ACT : ~C_HS_ACT;
      r_vsync <= ((r_v >= C_VS_START) && (r_v < C_VS_STOP)) ? C_VS_ACT : ~C_VS_ACT;
      r_blank <= w_active;
      r_frame_start <= w_frame;
      r_rgb <= w_rgb;
    end
  end

  assign ram_addr    = r_ram_addr;
  assign font_addr   = r_font_addr;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign blank       = r_blank;
  assign frame_start = r_frame_start;
  assign red         = r_rgb[23:16];
  assign green       = r_rgb[15:8];
  assign blue        = r_rgb[7:0];

endmodule
`default_nettype wire
